multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Moore control FSM for the 16-bit multicycle datapath. Decodes opcode ir[15:12], sequences
//  fetch/decode/execute/memory/writeback, and drives every datapath enable plus the 2-bit
//  selects of the 4:1 16-bit muxes (ALU-B source, PC source). Sits directly upstream of those muxes.
// PARAMETERS
//  OPW       4     opcode width (ir[15:12])
//  ST_W      4     state register width
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  opcode       in   4   instruction register bits [15:12]
//  zero         in   1   ALU zero flag, valid in BRANCH state
//  mem_ready    in   1   memory handshake (used only with MEM_WAIT_EN)
//  pc_en        out  1   PC load = pc_write | (pc_write_cond & zero)
//  ir_write     out  1   load instruction register
//  i_or_d       out  1   memory address: 0 PC, 1 ALUOut
//  mem_read     out  1   memory read strobe
//  mem_write    out  1   memory write strobe
//  reg_write    out  1   register file write enable
//  reg_dst      out  1   dest: 0 ir[7:4] (I-type), 1 ir[3:0] (R-type)
//  mem_to_reg   out  1   writeback data: 0 ALUOut, 1 MDR
//  alu_src_a    out  1   0 PC, 1 reg A
//  alu_src_b    out  2   0 reg B, 1 const 1, 2 sext(ir[7:0]), 3 sext(ir[7:0]) branch offset
//  alu_op       out  2   0 add, 1 sub, 2 funct ir[3:0], 3 reserved
//  pc_src       out  2   0 ALU result, 1 ALUOut, 2 jump {PC[15:12],ir[11:0]}, 3 unused
//  illegal_op   out  1   one-cycle pulse in DECODE on unknown opcode
//  state        out  4   current state (debug)
// BEHAVIOUR
//  - Opcodes: 0 RTYPE, 1 LW, 2 SW, 3 BEQ, 4 J, 5 ADDI; 6..15 illegal.
//  - States: FETCH0 DECODE1 MEMADR2 MEMRD3 MEMWB4 MEMWR5 EXEC6 ALUWB7 BRANCH8 JUMP9 ADDIEX10 ADDIWB11.
//  - rst asserted (any time, mid-instruction included): state=FETCH immediately; all outputs 0 while rst
//    high; first rising edge after release executes FETCH. Codes 12..15 unreachable; if entered -> FETCH.
//  - FETCH: mem_read, ir_write, alu_src_a=0, alu_src_b=1, alu_op=0, pc_src=0, pc_write -> DECODE.
//  - DECODE: alu_src_a=0, alu_src_b=3, alu_op=0 (branch target to ALUOut). Next: LW/SW->MEMADR,
//    RTYPE->EXEC, BEQ->BRANCH, J->JUMP, ADDI->ADDIEX, illegal->FETCH with illegal_op=1.
//  - MEMADR: alu_src_a=1, alu_src_b=2, alu_op=0 -> MEMRD (LW) or MEMWR (SW).
//  - MEMRD: mem_read, i_or_d=1 -> MEMWB. MEMWB: reg_write, mem_to_reg=1, reg_dst=0 -> FETCH.
//  - MEMWR: mem_write, i_or_d=1 -> FETCH.
//  - EXEC: alu_src_a=1, alu_src_b=0, alu_op=2 -> ALUWB. ALUWB: reg_write, reg_dst=1 -> FETCH.
//  - BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond, pc_src=1 -> FETCH; pc_en=zero.
//  - JUMP: pc_write, pc_src=2 -> FETCH. ADDIEX: alu_src_a=1, alu_src_b=2, alu_op=0 -> ADDIWB.
//    ADDIWB: reg_write, reg_dst=0, mem_to_reg=0 -> FETCH.
//  - Outputs not listed for a state are 0. Outputs decoded from registered state only, except pc_en
//    (combinational with zero). CPI: LW 5, SW/R/ADDI 4, BEQ/J 3.
// CONFIGURATION
//  MULTICYCLE_CTRL_MEM_WAIT_EN
//   defined: FETCH, MEMRD, MEMWR hold (outputs held, pc_write/ir_write gated to 0) until mem_ready=1;
//     advance and strobe pc_write/ir_write only in the mem_ready=1 cycle.
//   undefined: mem_ready ignored; every memory state is exactly one cycle.
// TESTING
//  1 rst=1 mid-MEMRD of LW -> state=0, all outputs 0 same cycle; after release FETCH with pc_en=1.
//  2 opcode=1 (LW) -> states 0,1,2,3,4,0; MEMWB has reg_write=1 mem_to_reg=1; 5 cycles.
//  3 opcode=3 zero=1 -> BRANCH pc_en=1 pc_src=1; repeat zero=0 -> pc_en=0; both return to FETCH.
//  4 opcode=4 -> JUMP pc_src=2 pc_en=1; opcode=0 -> EXEC alu_src_b=0 alu_op=2, ALUWB reg_dst=1.
//  5 opcode=9 -> DECODE illegal_op=1 for one cycle, next state FETCH, no reg_write/mem_write ever.
//  6 MEM_WAIT_EN, mem_ready=0 for 3 cycles in FETCH -> state stays 0, pc_en=0; ready=1 -> pc_en=1, DECODE.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the 16-bit multicycle datapath.
// Optional memory handshake stalls are enabled by defining MULTICYCLE_CTRL_MEM_WAIT_EN.
module multicycle_ctrl #(
  parameter int OPW  = 4,
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OPW-1:0]  opcode,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            pc_en,
  output logic            ir_write,
  output logic            i_or_d,
  output logic            mem_read,
  output logic            mem_write,
  output logic            reg_write,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      alu_op,
  output logic [1:0]      pc_src,
  output logic            illegal_op,
  output logic [ST_W-1:0] state
);

  typedef enum logic [ST_W-1:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    JUMP    = 4'd9,
    ADDIEX  = 4'd10,
    ADDIWB  = 4'd11
  } state_t;

  localparam logic [OPW-1:0] OP_RTYPE = 4'd0;
  localparam logic [OPW-1:0] OP_LW    = 4'd1;
  localparam logic [OPW-1:0] OP_SW    = 4'd2;
  localparam logic [OPW-1:0] OP_BEQ   = 4'd3;
  localparam logic [OPW-1:0] OP_J     = 4'd4;
  localparam logic [OPW-1:0] OP_ADDI  = 4'd5;

  state_t state_q, state_d;
  logic   mem_ok;
  logic   pc_write, pc_write_cond;

`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok           = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_op        = 2'd0;
    pc_src        = 2'd0;
    illegal_op    = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        ir_write  = mem_ok;
        pc_write  = mem_ok;
        if (mem_ok) state_d = DECODE;
      end
      DECODE: begin
        alu_src_b = 2'd3;
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDIEX;
          default: begin
            illegal_op = 1'b1;
            state_d    = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = (opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ok) state_d = MEMWB;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ok) state_d = FETCH;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'd2;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'd1;
        pc_write_cond = 1'b1;
        pc_src        = 2'd1;
        state_d       = FETCH;
      end
      JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'd2;
        state_d  = FETCH;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = ADDIWB;
      end
      ADDIWB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      default: state_d = FETCH;
    endcase
    // Reset forces a quiet control word even though the register already reads FETCH.
    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'd0;
      alu_op        = 2'd0;
      pc_src        = 2'd0;
      illegal_op    = 1'b0;
    end
  end

  assign pc_en = pc_write | (pc_write_cond & zero);
  assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; each state's full control word is checked.
// Control word bit order: pc_en ir_write i_or_d mem_read mem_write reg_write reg_dst mem_to_reg
// alu_src_a alu_src_b[1:0] alu_op[1:0] pc_src[1:0] illegal_op.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en, ir_write, i_or_d, mem_read, mem_write, reg_write;
  logic       reg_dst, mem_to_reg, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  localparam logic [15:0] W_ZERO    = 16'h0000;
  localparam logic [15:0] W_FETCH   = 16'hD020;
  localparam logic [15:0] W_FSTALL  = 16'h1020;
  localparam logic [15:0] W_DECODE  = 16'h0060;
  localparam logic [15:0] W_ILLEGAL = 16'h0061;
  localparam logic [15:0] W_MEMADR  = 16'h00C0;
  localparam logic [15:0] W_MEMRD   = 16'h3000;
  localparam logic [15:0] W_MEMWB   = 16'h0500;
  localparam logic [15:0] W_MEMWR   = 16'h2800;
  localparam logic [15:0] W_EXEC    = 16'h0090;
  localparam logic [15:0] W_ALUWB   = 16'h0600;
  localparam logic [15:0] W_BR_T    = 16'h808A;
  localparam logic [15:0] W_BR_NT   = 16'h008A;
  localparam logic [15:0] W_JUMP    = 16'h8004;
  localparam logic [15:0] W_ADDIEX  = 16'h00C0;
  localparam logic [15:0] W_ADDIWB  = 16'h0400;

  logic [15:0] word;
  assign word = {pc_en, ir_write, i_or_d, mem_read, mem_write, reg_write, reg_dst, mem_to_reg,
                 alu_src_a, alu_src_b, alu_op, pc_src, illegal_op};

  multicycle_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_en      (pc_en),
    .ir_write   (ir_write),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .illegal_op (illegal_op),
    .state      (state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, required completion before 200000");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1; opcode = 4'd1; zero = 1'b0; mem_ready = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0 || word !== W_ZERO) begin
      errors++;
      $display("FAIL reset_hold: state=%0d word=%h, required state=0 word=%h", state, word, W_ZERO);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || word !== W_FETCH) begin
      errors++;
      $display("FAIL reset_release: state=%0d word=%h, required state=0 word=%h", state, word, W_FETCH);
    end
    for (int i = 0; i < 3; i++) @(negedge clk);
    #1;
    checks++;
    if (state !== 4'd3 || word !== W_MEMRD) begin
      errors++;
      $display("FAIL reset_reach_memrd: state=%0d word=%h, required state=3 word=%h", state, word, W_MEMRD);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0 || word !== W_ZERO) begin
      errors++;
      $display("FAIL reset_mid_memrd: state=%0d word=%h, required state=0 word=%h", state, word, W_ZERO);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || word !== W_FETCH || pc_en !== 1'b1) begin
      errors++;
      $display("FAIL reset_refetch: state=%0d word=%h, required state=0 word=%h", state, word, W_FETCH);
    end
  endtask

  task automatic test_lw();
    logic [3:0]  st[6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    logic [15:0] wd[6] = '{W_FETCH, W_DECODE, W_MEMADR, W_MEMRD, W_MEMWB, W_FETCH};
    opcode = 4'd1;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (state !== st[i] || word !== wd[i]) begin
        errors++;
        $display("FAIL lw_cycle%0d: state=%0d word=%h, required state=%0d word=%h", i, state, word, st[i], wd[i]);
      end
      if (i < 5) @(negedge clk);
    end
  endtask

  task automatic test_sw_addi();
    logic [3:0]  st[10] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd1, 4'd10, 4'd11, 4'd0, 4'd0};
    logic [15:0] wd[10] = '{W_FETCH, W_DECODE, W_MEMADR, W_MEMWR, W_FETCH,
                            W_DECODE, W_ADDIEX, W_ADDIWB, W_FETCH, W_FETCH};
    opcode = 4'd2;
    for (int i = 0; i < 9; i++) begin
      if (i == 4) opcode = 4'd5;
      #1;
      checks++;
      if (state !== st[i] || word !== wd[i]) begin
        errors++;
        $display("FAIL sw_addi_cycle%0d: state=%0d word=%h, required state=%0d word=%h", i, state, word, st[i], wd[i]);
      end
      if (i < 8) @(negedge clk);
    end
  endtask

  task automatic test_branch();
    for (int z = 1; z >= 0; z--) begin
      opcode = 4'd3; zero = z[0];
      @(negedge clk);
      #1;
      checks++;
      if (state !== 4'd1 || word !== W_DECODE) begin
        errors++;
        $display("FAIL beq_decode_z%0d: state=%0d word=%h, required state=1 word=%h", z, state, word, W_DECODE);
      end
      @(negedge clk);
      #1;
      checks++;
      if (state !== 4'd8 || word !== (z == 1 ? W_BR_T : W_BR_NT)) begin
        errors++;
        $display("FAIL beq_branch_z%0d: state=%0d word=%h, required state=8 word=%h", z, state, word,
                 (z == 1 ? W_BR_T : W_BR_NT));
      end
      @(negedge clk);
      #1;
      checks++;
      if (state !== 4'd0 || word !== W_FETCH) begin
        errors++;
        $display("FAIL beq_return_z%0d: state=%0d word=%h, required state=0 word=%h", z, state, word, W_FETCH);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_jump_rtype();
    logic [3:0]  st[7] = '{4'd1, 4'd9, 4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    logic [15:0] wd[7] = '{W_DECODE, W_JUMP, W_FETCH, W_DECODE, W_EXEC, W_ALUWB, W_FETCH};
    opcode = 4'd4;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i == 2) opcode = 4'd0;
      #1;
      checks++;
      if (state !== st[i] || word !== wd[i]) begin
        errors++;
        $display("FAIL j_r_cycle%0d: state=%0d word=%h, required state=%0d word=%h", i, state, word, st[i], wd[i]);
      end
    end
  endtask

  task automatic test_illegal();
    opcode = 4'd9;
    @(negedge clk);
    #1;
    checks++;
    if (state !== 4'd1 || word !== W_ILLEGAL) begin
      errors++;
      $display("FAIL illegal_decode: state=%0d word=%h, required state=1 word=%h", state, word, W_ILLEGAL);
    end
    @(negedge clk);
    #1;
    checks++;
    if (state !== 4'd0 || word !== W_FETCH) begin
      errors++;
      $display("FAIL illegal_return: state=%0d word=%h, required state=0 word=%h", state, word, W_FETCH);
    end
    @(negedge clk);
    #1;
    checks++;
    if (state !== 4'd1 || illegal_op !== 1'b1 || reg_write !== 1'b0 || mem_write !== 1'b0) begin
      errors++;
      $display("FAIL illegal_repeat: state=%0d illegal_op=%b, required state=1 illegal_op=1", state, illegal_op);
    end
    @(negedge clk);
    opcode = 4'd4;
  endtask

  task automatic test_mem_ready();
    mem_ready = 1'b0;
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (state !== 4'd0 || word !== W_FSTALL) begin
        errors++;
        $display("FAIL fetch_stall%0d: state=%0d word=%h, required state=0 word=%h", i, state, word, W_FSTALL);
      end
      @(negedge clk);
    end
    mem_ready = 1'b1;
`endif
    #1;
    checks++;
    if (state !== 4'd0 || word !== W_FETCH) begin
      errors++;
      $display("FAIL fetch_ready: state=%0d word=%h, required state=0 word=%h", state, word, W_FETCH);
    end
    opcode = 4'd4;
    @(negedge clk);
    #1;
    checks++;
    if (state !== 4'd1 || word !== W_DECODE) begin
      errors++;
      $display("FAIL fetch_advance: state=%0d word=%h, required state=1 word=%h", state, word, W_DECODE);
    end
    @(negedge clk); @(negedge clk);
    mem_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_addi();
    test_branch();
    test_jump_rtype();
    test_illegal();
    test_mem_ready();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
